// File: rtl/riscv_v_csr_wr_sched.sv
// riscv_v_csr_wr_sched
//   Arbitrates CSR write requests from the scalar core (ext) and the vector
//   unit (vec) onto one registered vector-CSR write port. Single CSR ops take
//   one write slot. vsetvl expands into an atomic vtype -> vl -> vstart=0
//   sequence and reports the granted vl on the rsp_* port.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   stall_i                  freezes FSM, grants and masks the write port
//   flush_i                  blocks new accepts; accepted work completes
//   {ext,vec}_req_valid_i    request valid
//   {ext,vec}_req_ready_o    request accepted on valid & ready
//   {ext,vec}_req_op_i       0 vsstatus,1 vtype,2 vl,3 vstart,4 vxrm,5 vxsat,
//                            6 vsetvl,7 reserved (no write)
//   {ext,vec}_req_data_i     write data, or AVL for vsetvl
//   {ext,vec}_req_vtype_i    vsetvl vtype {ignored,vma,vta,vsew[2:0],vlmul[2:0]}
//   csr_wr_en_o              one-hot CSR write enable, bit index = op
//   csr_wr_data_o            zero-extended write data
//   rsp_valid_o/src_o/vl_o   vsetvl result pulse, source (1=vec), granted vl
//   busy_o                   a write slot is in progress
//   state_o                  FSM state, for observation
//
// Handshake: a request transfers on the rising edge where valid & ready are
// both high. ready is only ever raised towards the requester that currently
// wins arbitration, and never while stalled, flushed or in reset. Once a
// request has transferred it cannot be withdrawn by flush.
module riscv_v_csr_wr_sched #(
    parameter int VLEN     = 128,
    parameter int VL_WIDTH = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                stall_i,
    input  logic                flush_i,
    input  logic                ext_req_valid_i,
    output logic                ext_req_ready_o,
    input  logic [2:0]          ext_req_op_i,
    input  logic [31:0]         ext_req_data_i,
    input  logic [8:0]          ext_req_vtype_i,
    input  logic                vec_req_valid_i,
    output logic                vec_req_ready_o,
    input  logic [2:0]          vec_req_op_i,
    input  logic [31:0]         vec_req_data_i,
    input  logic [8:0]          vec_req_vtype_i,
    output logic [5:0]          csr_wr_en_o,
    output logic [31:0]         csr_wr_data_o,
    output logic                rsp_valid_o,
    output logic                rsp_src_o,
    output logic [VL_WIDTH-1:0] rsp_vl_o,
    output logic                busy_o,
    output logic [1:0]          state_o
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        WR_VL     = 2'd2,
        WR_VSTART = 2'd3
    } state_e;

    localparam logic [2:0]  OP_VSETVL = 3'd6;
    localparam logic [2:0]  OP_RSVD   = 3'd7;
    localparam logic [31:0] VLEN_W    = 32'(VLEN);

    state_e              state_q, state_d;
    logic                prio_q, prio_d;     // 0 = ext preferred, 1 = vec
    logic [2:0]          op_q, op_d;
    logic                src_q, src_d;
    logic [VL_WIDTH-1:0] vl_q, vl_d;
    logic [5:0]          wr_en_q, wr_en_d;
    logic [31:0]         wr_data_q, wr_data_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_src_q, rsp_src_d;
    logic [VL_WIDTH-1:0] rsp_vl_q, rsp_vl_d;

    // Arbitration and acceptance
    logic        sel_vec, can_accept, accept;
    logic [2:0]  req_op;
    logic [31:0] req_data;
    logic [8:0]  req_vtype;

    assign sel_vec    = vec_req_valid_i & (~ext_req_valid_i | prio_q);
    assign req_op     = sel_vec ? vec_req_op_i    : ext_req_op_i;
    assign req_data   = sel_vec ? vec_req_data_i  : ext_req_data_i;
    assign req_vtype  = sel_vec ? vec_req_vtype_i : ext_req_vtype_i;

    // A new request may overlap the last slot of a single op, never a vsetvl.
    assign can_accept = rst_ni & ~stall_i & ~flush_i &
                        ((state_q == IDLE) | ((state_q == WRITE) & (op_q != OP_VSETVL)));
    assign accept          = can_accept & (ext_req_valid_i | vec_req_valid_i);
    assign ext_req_ready_o = can_accept & ext_req_valid_i & ~sel_vec;
    assign vec_req_ready_o = can_accept & sel_vec;

    // vsetvl: VLMAX and vl, resolved at accept time
    logic [2:0]          vlmul, vsew;
    logic [1:0]          lmul_rsh;
    logic [31:0]         sew_elems, vlmax, avl_vl;
    logic                vill;
    logic [8:0]          vtype_wr;
    logic [VL_WIDTH-1:0] vl_calc;

    assign vlmul     = req_vtype[2:0];
    assign vsew      = req_vtype[5:3];
    // Fractional LMUL 5/6/7 divides by 8/4/2, i.e. shift right by 4 - vlmul[1:0].
    assign lmul_rsh  = 2'd0 - vlmul[1:0];
    assign sew_elems = (VLEN_W >> 3) >> vsew;
    assign vlmax     = vlmul[2] ? (sew_elems >> lmul_rsh) : (sew_elems << vlmul[1:0]);
    assign vill      = (vsew > 3'd4) | (vlmul == 3'd4) | (vlmax == 32'd0);
    assign vtype_wr  = vill ? 9'h100 : {1'b0, req_vtype[7:0]};
    assign avl_vl    = (req_data < vlmax) ? req_data : vlmax;
    assign vl_calc   = vill ? '0 : VL_WIDTH'(avl_vl);

    // vtype[8] is defined as ignored on both requesters.
    logic unused_vtype_msb;
    assign unused_vtype_msb = ext_req_vtype_i[8] ^ vec_req_vtype_i[8];

    // Next state and next registered outputs
    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        op_d        = op_q;
        src_d       = src_q;
        vl_d        = vl_q;
        wr_en_d     = '0;
        wr_data_d   = '0;
        rsp_valid_d = 1'b0;
        rsp_src_d   = rsp_src_q;
        rsp_vl_d    = rsp_vl_q;

        if (stall_i) begin
            // Hold everything; the port is masked at the outputs instead.
            wr_en_d     = wr_en_q;
            wr_data_d   = wr_data_q;
            rsp_valid_d = rsp_valid_q;
        end else begin
            unique case (state_q)
                IDLE, WRITE: begin
                    if ((state_q == WRITE) && (op_q == OP_VSETVL)) begin
                        state_d     = WR_VL;
                        wr_en_d     = 6'b000100;
                        wr_data_d   = 32'(vl_q);
                        rsp_valid_d = 1'b1;
                        rsp_src_d   = src_q;
                        rsp_vl_d    = vl_q;
                    end else if (accept) begin
                        state_d = WRITE;
                        op_d    = req_op;
                        src_d   = sel_vec;
                        prio_d  = ~sel_vec;   // loser gets priority next time
                        vl_d    = vl_calc;
                        if (req_op == OP_VSETVL) begin
                            wr_en_d   = 6'b000010;
                            wr_data_d = 32'(vtype_wr);
                        end else if (req_op != OP_RSVD) begin
                            wr_en_d   = 6'd1 << req_op;
                            wr_data_d = req_data;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                WR_VL: begin
                    state_d = WR_VSTART;
                    wr_en_d = 6'b001000;
                end
                WR_VSTART: begin
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            prio_q      <= 1'b0;
            op_q        <= '0;
            src_q       <= 1'b0;
            vl_q        <= '0;
            wr_en_q     <= '0;
            wr_data_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_src_q   <= 1'b0;
            rsp_vl_q    <= '0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            op_q        <= op_d;
            src_q       <= src_d;
            vl_q        <= vl_d;
            wr_en_q     <= wr_en_d;
            wr_data_q   <= wr_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_src_q   <= rsp_src_d;
            rsp_vl_q    <= rsp_vl_d;
        end
    end

    // A stalled cycle shows no write; the held slot reappears once released.
    assign csr_wr_en_o   = wr_en_q & {6{~stall_i}};
    assign csr_wr_data_o = wr_data_q;
    assign rsp_valid_o   = rsp_valid_q & ~stall_i;
    assign rsp_src_o     = rsp_src_q;
    assign rsp_vl_o      = rsp_vl_q;
    assign busy_o        = (state_q != IDLE);
    assign state_o       = state_q;

endmodule

// File: tb/tb_riscv_v_csr_wr_sched.sv
module tb_riscv_v_csr_wr_sched;
  localparam int VLEN = 128;
  localparam int VL_WIDTH = 8;

  typedef struct packed {
    logic [5:0]  en;
    logic [31:0] data;
    logic        rsp;
    logic        src;
    logic [7:0]  vl;
    logic        seq;
  } slot_t;
  localparam int SLOT_W = $bits(slot_t);

  logic clk, rst_n, stall, flush;
  logic ext_v, ext_r, vec_v, vec_r;
  logic [2:0] ext_op, vec_op;
  logic [31:0] ext_d, vec_d;
  logic [8:0] ext_vt, vec_vt;
  logic [5:0] csr_wr_en;
  logic [31:0] csr_wr_data;
  logic rsp_valid, rsp_src, busy;
  logic [VL_WIDTH-1:0] rsp_vl;
  logic [1:0] state;

  riscv_v_csr_wr_sched #(.VLEN(VLEN), .VL_WIDTH(VL_WIDTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .stall_i(stall), .flush_i(flush),
    .ext_req_valid_i(ext_v), .ext_req_ready_o(ext_r), .ext_req_op_i(ext_op),
    .ext_req_data_i(ext_d), .ext_req_vtype_i(ext_vt),
    .vec_req_valid_i(vec_v), .vec_req_ready_o(vec_r), .vec_req_op_i(vec_op),
    .vec_req_data_i(vec_d), .vec_req_vtype_i(vec_vt),
    .csr_wr_en_o(csr_wr_en), .csr_wr_data_o(csr_wr_data),
    .rsp_valid_o(rsp_valid), .rsp_src_o(rsp_src), .rsp_vl_o(rsp_vl),
    .busy_o(busy), .state_o(state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int failures = 0;

  // reference model: queue of pending write slots, head = slot on the port
  logic [SLOT_W-1:0] exp_q[$];
  logic m_ptr;
  logic [5:0] m_en;
  logic [31:0] m_data;
  logic m_rsp, m_src, m_busy, m_er, m_vr;
  logic [7:0] m_vl;

  function automatic int unsigned ref_vlmax(input logic [8:0] vt);
    int unsigned sew, num, den;
    if (vt[5:3] > 3'd4 || vt[2:0] == 3'd4) return 0;
    sew = 8 * (1 << vt[5:3]);
    case (vt[2:0])
      3'd0: begin num = 1; den = 1; end
      3'd1: begin num = 2; den = 1; end
      3'd2: begin num = 4; den = 1; end
      3'd3: begin num = 8; den = 1; end
      3'd5: begin num = 1; den = 8; end
      3'd6: begin num = 1; den = 4; end
      default: begin num = 1; den = 2; end
    endcase
    return (VLEN * num) / (sew * den);
  endfunction

  function automatic logic model_can_accept();
    slot_t h;
    if (!rst_n || stall || flush) return 1'b0;
    if (exp_q.size() == 0) return 1'b1;
    h = slot_t'(exp_q[0]);
    return (exp_q.size() == 1) && !h.seq;
  endfunction

  function automatic logic model_ext_wins();
    return ext_v && (!vec_v || !m_ptr);
  endfunction

  task automatic push_txn(input logic src, input logic [2:0] op, input logic [31:0] d,
                          input logic [8:0] vt);
    slot_t s;
    int unsigned vmax;
    logic [31:0] vlv;
    s = '0;
    if (op <= 3'd5) begin
      s.en = 6'd1 << op;
      s.data = d;
      exp_q.push_back(SLOT_W'(s));
    end else if (op == 3'd7) begin
      exp_q.push_back(SLOT_W'(s));
    end else begin
      vmax = ref_vlmax(vt);
      s.seq = 1'b1;
      s.en = 6'b000010;
      s.data = (vmax != 0) ? {24'd0, vt[7:0]} : 32'h100;
      exp_q.push_back(SLOT_W'(s));
      vlv = (vmax == 0) ? 32'd0 : ((d < vmax) ? d : vmax);
      s.en = 6'b000100;
      s.data = vlv;
      s.rsp = 1'b1;
      s.src = src;
      s.vl = vlv[7:0];
      exp_q.push_back(SLOT_W'(s));
      s = '0;
      s.seq = 1'b1;
      s.en = 6'b001000;
      exp_q.push_back(SLOT_W'(s));
    end
  endtask

  task automatic model_edge();
    logic ok, ew;
    if (!rst_n) begin
      exp_q.delete();
      m_ptr = 1'b0;
      return;
    end
    if (stall) return;
    ok = model_can_accept();
    ew = model_ext_wins();
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    if (ok && (ext_v || vec_v)) begin
      if (ew) push_txn(1'b0, ext_op, ext_d, ext_vt);
      else push_txn(1'b1, vec_op, vec_d, vec_vt);
      m_ptr = ew;
    end
  endtask

  task automatic model_expect();
    slot_t h;
    logic have, ok, ew;
    have = exp_q.size() > 0;
    h = have ? slot_t'(exp_q[0]) : slot_t'('0);
    m_en = (have && !stall) ? h.en : 6'd0;
    m_data = h.data;
    m_rsp = have && !stall && h.rsp;
    m_src = h.src;
    m_vl = h.vl;
    m_busy = have;
    ok = model_can_accept();
    ew = model_ext_wins();
    m_er = ok && ext_v && ew;
    m_vr = ok && vec_v && !ew;
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_ext(input logic v, input logic [2:0] op, input logic [31:0] d,
                         input logic [8:0] vt);
    ext_v = v; ext_op = op; ext_d = d; ext_vt = vt;
  endtask

  task automatic set_vec(input logic v, input logic [2:0] op, input logic [31:0] d,
                         input logic [8:0] vt);
    vec_v = v; vec_op = op; vec_d = d; vec_vt = vt;
  endtask

  task automatic clear_reqs();
    set_ext(1'b0, 3'd0, 32'd0, 9'd0);
    set_vec(1'b0, 3'd0, 32'd0, 9'd0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // scenarios
  task automatic test_reset();
    set_ext(1'b1, 3'd1, 32'h7, 9'd0);
    set_vec(1'b1, 3'd2, 32'h9, 9'd0);
    #1;
    checks++;
    if ({csr_wr_en, csr_wr_data, rsp_valid, rsp_src, rsp_vl, busy} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got en=%b data=%h rv=%b rs=%b vl=%0d busy=%b exp all 0",
               csr_wr_en, csr_wr_data, rsp_valid, rsp_src, rsp_vl, busy);
    end
    checks++;
    if ({ext_r, vec_r} !== 2'b00) begin
      failures++; $display("FAIL reset_ready got=%b exp=00", {ext_r, vec_r});
    end
    clear_reqs();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_op();
    set_ext(1'b1, 3'd4, 32'd2, 9'd0);
    #1;
    checks++;
    if ({ext_r, vec_r} !== 2'b10) begin
      failures++; $display("FAIL single_ready got=%b exp=10", {ext_r, vec_r});
    end
    tick();
    clear_reqs();
    #1;
    checks++;
    if (csr_wr_en !== 6'b010000 || csr_wr_data !== 32'd2) begin
      failures++; $display("FAIL single_write got en=%b data=%h exp en=010000 data=2", csr_wr_en, csr_wr_data);
    end
    tick();
    #1;
    checks++;
    if (busy !== 1'b0 || csr_wr_en !== 6'd0) begin
      failures++; $display("FAIL single_idle got busy=%b en=%b exp 0/0", busy, csr_wr_en);
    end
  endtask

  task automatic test_round_robin();
    logic [31:0] last_d;
    pulse_reset();
    last_d = 32'd0;
    for (int i = 0; i < 4; i++) begin
      set_ext(1'b1, 3'd3, 32'h100 + i, 9'd0);
      set_vec(1'b1, 3'd3, 32'h200 + i, 9'd0);
      #1;
      checks++;
      if ({ext_r, vec_r} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        failures++; $display("FAIL rr_grant i=%0d got=%b exp=%b", i, {ext_r, vec_r}, (i % 2 == 0) ? 2'b10 : 2'b01);
      end
      if (i > 0) begin
        checks++;
        if (csr_wr_en !== 6'b001000 || csr_wr_data !== last_d) begin
          failures++; $display("FAIL rr_write i=%0d got en=%b data=%h exp en=001000 data=%h", i, csr_wr_en, csr_wr_data, last_d);
        end
      end
      last_d = (i % 2 == 0) ? 32'h100 + i : 32'h200 + i;
      tick();
    end
    clear_reqs();
    #1;
    checks++;
    if (csr_wr_en !== 6'b001000 || csr_wr_data !== last_d) begin
      failures++; $display("FAIL rr_last got en=%b data=%h exp en=001000 data=%h", csr_wr_en, csr_wr_data, last_d);
    end
    tick();
  endtask

  task automatic test_vsetvl_vec();
    set_vec(1'b1, 3'd6, 32'd200, 9'h003);
    #1;
    checks++;
    if (vec_r !== 1'b1) begin failures++; $display("FAIL vs_accept got=%b exp=1", vec_r); end
    tick();
    clear_reqs();
    set_ext(1'b1, 3'd0, 32'h55, 9'd0);
    #1;
    checks++;
    if (csr_wr_en !== 6'b000010 || csr_wr_data !== 32'h003 || ext_r !== 1'b0) begin
      failures++; $display("FAIL vs_vtype got en=%b data=%h rdy=%b exp 000010/3/0", csr_wr_en, csr_wr_data, ext_r);
    end
    tick();
    #1;
    checks++;
    if (csr_wr_en !== 6'b000100 || csr_wr_data !== 32'd128 || ext_r !== 1'b0) begin
      failures++; $display("FAIL vs_vl got en=%b data=%0d rdy=%b exp 000100/128/0", csr_wr_en, csr_wr_data, ext_r);
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_src !== 1'b1 || rsp_vl !== 8'd128) begin
      failures++; $display("FAIL vs_rsp got v=%b s=%b vl=%0d exp 1/1/128", rsp_valid, rsp_src, rsp_vl);
    end
    tick();
    #1;
    checks++;
    if (csr_wr_en !== 6'b001000 || csr_wr_data !== 32'd0 || ext_r !== 1'b0 || rsp_valid !== 1'b0) begin
      failures++; $display("FAIL vs_vstart got en=%b data=%h rdy=%b rv=%b exp 001000/0/0/0", csr_wr_en, csr_wr_data, ext_r, rsp_valid);
    end
    tick();
    #1;
    checks++;
    if (ext_r !== 1'b1) begin failures++; $display("FAIL vs_after_ready got=%b exp=1", ext_r); end
    tick();
    clear_reqs();
    #1;
    checks++;
    if (csr_wr_en !== 6'b000001 || csr_wr_data !== 32'h55) begin
      failures++; $display("FAIL vs_after_write got en=%b data=%h exp 000001/55", csr_wr_en, csr_wr_data);
    end
    tick();
  endtask

  task automatic test_vill();
    set_ext(1'b1, 3'd6, 32'd5, 9'h025);
    tick();
    clear_reqs();
    #1;
    checks++;
    if (csr_wr_en !== 6'b000010 || csr_wr_data !== 32'h100) begin
      failures++; $display("FAIL vill_vtype got en=%b data=%h exp 000010/100", csr_wr_en, csr_wr_data);
    end
    tick();
    #1;
    checks++;
    if (csr_wr_en !== 6'b000100 || csr_wr_data !== 32'd0 || rsp_vl !== 8'd0 || rsp_src !== 1'b0) begin
      failures++; $display("FAIL vill_vl got en=%b data=%0d vl=%0d src=%b exp 000100/0/0/0", csr_wr_en, csr_wr_data, rsp_vl, rsp_src);
    end
    tick();
    #1;
    checks++;
    if (csr_wr_en !== 6'b001000) begin failures++; $display("FAIL vill_vstart got en=%b exp 001000", csr_wr_en); end
    tick();
    set_ext(1'b1, 3'd6, 32'd3, 9'h010);
    tick();
    clear_reqs();
    #1;
    checks++;
    if (csr_wr_data !== 32'h010) begin failures++; $display("FAIL legal_vtype got data=%h exp 010", csr_wr_data); end
    tick();
    #1;
    checks++;
    if (csr_wr_en !== 6'b000100 || csr_wr_data !== 32'd3 || rsp_vl !== 8'd3) begin
      failures++; $display("FAIL legal_vl got en=%b data=%0d vl=%0d exp 000100/3/3", csr_wr_en, csr_wr_data, rsp_vl);
    end
    tick();
    tick();
  endtask

  task automatic test_stall();
    int n_vl, n_vs;
    n_vl = 0; n_vs = 0;
    set_vec(1'b1, 3'd6, 32'd20, 9'h008);
    tick();
    clear_reqs();
    tick();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (csr_wr_en !== 6'd0 || rsp_valid !== 1'b0 || busy !== 1'b1) begin
        failures++; $display("FAIL stall_hold i=%0d got en=%b rv=%b busy=%b exp 0/0/1", i, csr_wr_en, rsp_valid, busy);
      end
      n_vl += int'(csr_wr_en[2]); n_vs += int'(csr_wr_en[3]);
      tick();
    end
    stall = 1'b0;
    #1;
    checks++;
    if (csr_wr_en !== 6'b000100 || csr_wr_data !== 32'd8 || rsp_valid !== 1'b1) begin
      failures++; $display("FAIL stall_vl got en=%b data=%0d rv=%b exp 000100/8/1", csr_wr_en, csr_wr_data, rsp_valid);
    end
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vl += int'(csr_wr_en[2]); n_vs += int'(csr_wr_en[3]);
      tick();
    end
    checks++;
    if (n_vl != 1 || n_vs != 1) begin
      failures++; $display("FAIL stall_once got vl=%0d vstart=%0d exp 1/1", n_vl, n_vs);
    end
  endtask

  task automatic test_flush();
    set_vec(1'b1, 3'd6, 32'd7, 9'h003);
    tick();
    clear_reqs();
    tick();
    flush = 1'b1;
    set_ext(1'b1, 3'd5, 32'd1, 9'd0);
    #1;
    checks++;
    if (ext_r !== 1'b0 || csr_wr_en !== 6'b000100 || csr_wr_data !== 32'd7) begin
      failures++; $display("FAIL flush_vl got rdy=%b en=%b data=%0d exp 0/000100/7", ext_r, csr_wr_en, csr_wr_data);
    end
    tick();
    flush = 1'b0;
    #1;
    checks++;
    if (csr_wr_en !== 6'b001000 || ext_r !== 1'b0) begin
      failures++; $display("FAIL flush_vstart got en=%b rdy=%b exp 001000/0", csr_wr_en, ext_r);
    end
    tick();
    flush = 1'b1;
    #1;
    checks++;
    if (ext_r !== 1'b0) begin failures++; $display("FAIL flush_block got=%b exp=0", ext_r); end
    tick();
    flush = 1'b0;
    #1;
    checks++;
    if (ext_r !== 1'b1) begin failures++; $display("FAIL flush_release got=%b exp=1", ext_r); end
    tick();
    clear_reqs();
    #1;
    checks++;
    if (csr_wr_en !== 6'b100000 || csr_wr_data !== 32'd1) begin
      failures++; $display("FAIL flush_write got en=%b data=%h exp 100000/1", csr_wr_en, csr_wr_data);
    end
    tick();
  endtask

  task automatic test_async_reset();
    set_vec(1'b1, 3'd6, 32'd50, 9'h003);
    tick();
    clear_reqs();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({csr_wr_en, csr_wr_data, rsp_valid, rsp_src, rsp_vl, busy} !== '0) begin
      failures++; $display("FAIL async_reset got en=%b data=%h rv=%b busy=%b exp all 0", csr_wr_en, csr_wr_data, rsp_valid, busy);
    end
    exp_q.delete();
    m_ptr = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (csr_wr_en !== 6'd0 || busy !== 1'b0) begin
        failures++; $display("FAIL async_abandon i=%0d got en=%b busy=%b exp 0/0", i, csr_wr_en, busy);
      end
      tick();
    end
  endtask

  function automatic logic [2:0] rand_op();
    int r;
    r = $urandom_range(0, 10);
    return (r < 3) ? 3'd6 : 3'(r - 3);
  endfunction

  function automatic logic [8:0] rand_vtype();
    logic [2:0] lm;
    if ($urandom_range(0, 3) == 0) return 9'($urandom);
    lm = 3'($urandom_range(0, 6));
    if (lm >= 3'd4) lm = lm + 3'd1;
    return {1'($urandom), 2'($urandom), 3'($urandom_range(0, 4)), lm};
  endfunction

  function automatic logic [31:0] rand_data();
    return ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 300)) : $urandom;
  endfunction

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      stall = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 9) == 0);
      set_ext(1'($urandom), rand_op(), rand_data(), rand_vtype());
      set_vec(1'($urandom), rand_op(), rand_data(), rand_vtype());
      #1;
      model_expect();
      checks++;
      if (csr_wr_en !== m_en || csr_wr_data !== m_data) begin
        failures++; $display("FAIL rand_write c=%0d got en=%b data=%h exp en=%b data=%h", c, csr_wr_en, csr_wr_data, m_en, m_data);
      end
      checks++;
      if (rsp_valid !== m_rsp || (m_rsp && (rsp_src !== m_src || rsp_vl !== m_vl))) begin
        failures++; $display("FAIL rand_rsp c=%0d got v=%b s=%b vl=%0d exp v=%b s=%b vl=%0d", c, rsp_valid, rsp_src, rsp_vl, m_rsp, m_src, m_vl);
      end
      checks++;
      if ({ext_r, vec_r, busy} !== {m_er, m_vr, m_busy}) begin
        failures++; $display("FAIL rand_ctrl c=%0d got er=%b vr=%b busy=%b exp er=%b vr=%b busy=%b", c, ext_r, vec_r, busy, m_er, m_vr, m_busy);
      end
      tick();
    end
    stall = 1'b0;
    flush = 1'b0;
    clear_reqs();
    repeat (4) tick();
  endtask

  // main sequence and final report
  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    m_ptr = 1'b0;
    clear_reqs();
    repeat (2) @(negedge clk);
    test_reset();
    test_single_op();
    test_round_robin();
    test_vsetvl_vec();
    test_vill();
    test_stall();
    test_flush();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
